// File: rtl/lpif_txrx_x8_asym2_full_slave_link_if.sv
// Slave-side LPIF logic-link bundle: RX FIFO word in, dstrm fields out,
// ustrm fields in, TX FIFO word out with ready/valid.
interface lpif_txrx_x8_asym2_full_slave_link_if #(
    parameter int ERR_CNT_W = 8
);
    logic [144:0]          rxfifo_downstream_data;
    logic                  rxfifo_downstream_vld;
    logic [3:0]            dstrm_state;
    logic [1:0]            dstrm_protid;
    logic [127:0]          dstrm_data;
    logic                  dstrm_dvalid;
    logic [7:0]            dstrm_crc;
    logic                  dstrm_crc_valid;
    logic                  dstrm_valid;
    logic                  dstrm_state_chg;
    logic [ERR_CNT_W-1:0]  err_cnt;
    logic                  err_clr;
    logic [3:0]            ustrm_state;
    logic [1:0]            ustrm_protid;
    logic [127:0]          ustrm_data;
    logic                  ustrm_dvalid;
    logic [7:0]            ustrm_crc;
    logic                  ustrm_crc_valid;
    logic                  ustrm_valid;
    logic                  ustrm_push;
    logic                  ustrm_rdy;
    logic [144:0]          txfifo_upstream_data;
    logic                  txfifo_upstream_vld;
    logic                  txfifo_upstream_rdy;

    modport slave (
        input  rxfifo_downstream_data,
        input  rxfifo_downstream_vld,
        output dstrm_state,
        output dstrm_protid,
        output dstrm_data,
        output dstrm_dvalid,
        output dstrm_crc,
        output dstrm_crc_valid,
        output dstrm_valid,
        output dstrm_state_chg,
        output err_cnt,
        input  err_clr,
        input  ustrm_state,
        input  ustrm_protid,
        input  ustrm_data,
        input  ustrm_dvalid,
        input  ustrm_crc,
        input  ustrm_crc_valid,
        input  ustrm_valid,
        input  ustrm_push,
        output ustrm_rdy,
        output txfifo_upstream_data,
        output txfifo_upstream_vld,
        input  txfifo_upstream_rdy
    );

    modport master (
        output rxfifo_downstream_data,
        output rxfifo_downstream_vld,
        input  dstrm_state,
        input  dstrm_protid,
        input  dstrm_data,
        input  dstrm_dvalid,
        input  dstrm_crc,
        input  dstrm_crc_valid,
        input  dstrm_valid,
        input  dstrm_state_chg,
        input  err_cnt,
        output err_clr,
        output ustrm_state,
        output ustrm_protid,
        output ustrm_data,
        output ustrm_dvalid,
        output ustrm_crc,
        output ustrm_crc_valid,
        output ustrm_valid,
        output ustrm_push,
        input  ustrm_rdy,
        input  txfifo_upstream_data,
        input  txfifo_upstream_vld,
        output txfifo_upstream_rdy
    );
endinterface

// File: rtl/lpif_txrx_x8_asym2_full_slave_link.sv
// Slave-end x8 asym2 full-rate LPIF link packer: registered RX unpack
// with integrity counting, and a 2-entry TX skid buffer toward the TX FIFO.
module lpif_txrx_x8_asym2_full_slave_link #(
    parameter int         ERR_CNT_W = 8,
    parameter logic [3:0] STATE_RST = 4'h0
) (
    input logic clk_wr,
    input logic rst_wr_n,
    lpif_txrx_x8_asym2_full_slave_link_if.slave link
);

    typedef struct packed {
        logic         valid;
        logic         crc_valid;
        logic [7:0]   crc;
        logic         dvalid;
        logic [127:0] data;
        logic [1:0]   protid;
        logic [3:0]   state;
    } word_t;

    typedef enum logic [1:0] {
        TX_EMPTY = 2'd0,
        TX_ONE   = 2'd1,
        TX_FULL  = 2'd2
    } tx_cnt_e;

    // ---------------- RX path ----------------
    word_t rx_w;
    logic  rx_vld;
    logic  rx_err;

    assign rx_w   = link.rxfifo_downstream_data;
    assign rx_vld = link.rxfifo_downstream_vld;
    assign rx_err = rx_vld & ~rx_w.valid
                  & (rx_w.dvalid | rx_w.crc_valid);

    logic [3:0]           state_q;
    logic [1:0]           protid_q;
    logic [127:0]         data_q;
    logic [7:0]           crc_q;
    logic                 dvalid_q;
    logic                 crc_valid_q;
    logic                 valid_q;
    logic                 chg_q;
    logic [ERR_CNT_W-1:0] err_q;

    // Capture word fields; valid bits are single-cycle pulses
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state_q     <= STATE_RST;
            protid_q    <= '0;
            data_q      <= '0;
            crc_q       <= '0;
            dvalid_q    <= 1'b0;
            crc_valid_q <= 1'b0;
            valid_q     <= 1'b0;
            chg_q       <= 1'b0;
        end else begin
            dvalid_q    <= rx_vld & rx_w.dvalid;
            crc_valid_q <= rx_vld & rx_w.crc_valid;
            valid_q     <= rx_vld & rx_w.valid;
            chg_q       <= rx_vld && (rx_w.state != state_q);
            if (rx_vld) begin
                state_q  <= rx_w.state;
                protid_q <= rx_w.protid;
                data_q   <= rx_w.data;
                crc_q    <= rx_w.crc;
            end
        end
    end

    // Saturating error counter; clear wins over increment
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            err_q <= '0;
        end else if (link.err_clr) begin
            err_q <= '0;
        end else if (rx_err && (err_q != '1)) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign link.dstrm_state     = state_q;
    assign link.dstrm_protid    = protid_q;
    assign link.dstrm_data      = data_q;
    assign link.dstrm_crc       = crc_q;
    assign link.dstrm_dvalid    = dvalid_q;
    assign link.dstrm_crc_valid = crc_valid_q;
    assign link.dstrm_valid     = valid_q;
    assign link.dstrm_state_chg = chg_q;
    assign link.err_cnt         = err_q;

    // ---------------- TX path ----------------
    word_t   push_w;
    tx_cnt_e cnt_q;
    tx_cnt_e cnt_d;
    word_t   e0_q;
    word_t   e0_d;
    word_t   e1_q;
    word_t   e1_d;
    logic    rdy_q;
    logic    push;
    logic    pop;

    assign push_w.state     = link.ustrm_state;
    assign push_w.protid    = link.ustrm_protid;
    assign push_w.data      = link.ustrm_data;
    assign push_w.dvalid    = link.ustrm_dvalid;
    assign push_w.crc       = link.ustrm_crc;
    assign push_w.crc_valid = link.ustrm_crc_valid;
    assign push_w.valid     = link.ustrm_valid;

    assign push = link.ustrm_push & rdy_q;
    assign pop  = (cnt_q != TX_EMPTY) & link.txfifo_upstream_rdy;

    // Skid buffer state: e0 is always the head entry
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            cnt_q <= TX_EMPTY;
            e0_q  <= '0;
            e1_q  <= '0;
            rdy_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            rdy_q <= (cnt_d != TX_FULL);
        end
    end

    // Next occupancy and entry shifting for push/pop combinations
    always_comb begin
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        unique case (cnt_q)
            TX_EMPTY: begin
                if (push) begin
                    e0_d  = push_w;
                    cnt_d = TX_ONE;
                end
            end
            TX_ONE: begin
                if (push && pop) begin
                    e0_d = push_w;
                end else if (push) begin
                    e1_d  = push_w;
                    cnt_d = TX_FULL;
                end else if (pop) begin
                    cnt_d = TX_EMPTY;
                end
            end
            TX_FULL: begin
                if (pop) begin
                    e0_d  = e1_q;
                    cnt_d = TX_ONE;
                end
            end
            default: begin
                cnt_d = TX_EMPTY;
            end
        endcase
    end

    assign link.ustrm_rdy            = rdy_q;
    assign link.txfifo_upstream_vld  = (cnt_q != TX_EMPTY);
    assign link.txfifo_upstream_data = e0_q;

endmodule

// File: doc/lpif_txrx_x8_asym2_full_slave_link.md
Name: lpif_txrx_x8_asym2_full_slave_link

Overview:
- Slave-end counterpart of the x8 asym2 full-rate LPIF logic-link packer.
- Receive path: accepts 145-bit downstream words from the slave RX FIFO, unpacks them into dstrm_* fields and registers them, with word-integrity checks.
- Transmit path: packs user ustrm_* fields into 145-bit upstream words through a 2-entry skid buffer with ready/valid backpressure toward the slave TX FIFO.
- Sits between the slave LPIF adapter and the AIB logic-link FIFOs.

Parameters:
ERR_CNT_W, 8, width of saturating protocol-error counter
STATE_RST, 4'h0, reset/idle value of the held dstrm_state

Ports:
clk_wr  in  1  link clock; all logic in this domain
rst_wr_n  in  1  asynchronous active-low reset
rxfifo_downstream_data  in  145  packed downstream word from RX FIFO
rxfifo_downstream_vld  in  1  word present this cycle
dstrm_state  out  4  held link state
dstrm_protid  out  2  protocol id of last captured word
dstrm_data  out  128  data of last captured word
dstrm_dvalid  out  1  data-valid pulse
dstrm_crc  out  8  crc of last captured word
dstrm_crc_valid  out  1  crc-valid pulse
dstrm_valid  out  1  word-valid pulse
dstrm_state_chg  out  1  one-cycle pulse when dstrm_state changes
err_cnt  out  ERR_CNT_W  saturating protocol-error count
err_clr  in  1  synchronous clear of err_cnt
ustrm_state  in  4  upstream state field
ustrm_protid  in  2  upstream protocol id
ustrm_data  in  128  upstream data
ustrm_dvalid  in  1  upstream data valid
ustrm_crc  in  8  upstream crc
ustrm_crc_valid  in  1  upstream crc valid
ustrm_valid  in  1  upstream word valid
ustrm_push  in  1  user offers word this cycle
ustrm_rdy  out  1  skid buffer can accept a word
txfifo_upstream_data  out  145  packed upstream word to TX FIFO
txfifo_upstream_vld  out  1  head word valid
txfifo_upstream_rdy  in  1  TX FIFO accepts head word

Behaviour:
- Word layout, both directions, LSB first:
  - [3:0] state
  - [5:4] protid
  - [133:6] data
  - [134] dvalid
  - [142:135] crc
  - [143] crc_valid
  - [144] valid
- Reset (rst_wr_n low, asynchronous):
  - dstrm_state=STATE_RST; all other dstrm_* outputs =0; dstrm_state_chg=0; err_cnt=0.
  - Skid buffer empty: txfifo_upstream_vld=0, txfifo_upstream_data=0, ustrm_rdy=0.
  - ustrm_rdy goes 1 on the first clock after reset release.
- RX capture, registered, latency 1:
  - Word with rxfifo_downstream_vld=1 at edge N drives outputs after edge N+1.
  - state/protid/data/crc load only on vld and hold otherwise.
  - dvalid/crc_valid/valid = word bits when vld, else forced 0 (pulses, never held).
- dstrm_state_chg = 1 in the cycle after a captured word whose state differs from the held dstrm_state; else 0.
- Protocol errors, evaluated only on vld words:
  - (a) dvalid=1 with valid=0.
  - (b) crc_valid=1 with valid=0.
  - (a) and (b) in the same word count as one error.
  - err_cnt increments by 1 per erroneous word and saturates at all-ones.
  - err_clr has priority over a same-cycle increment; the result is 0.
  - Erroneous words are still captured unchanged.
- TX skid buffer: 2 entries, count 0..2, FIFO order.
  - ustrm_rdy = (count<2), registered from count.
  - Push = ustrm_push & ustrm_rdy; push with ustrm_rdy=0 is dropped, no error.
  - txfifo_upstream_vld = (count!=0); txfifo_upstream_data = head entry, registered.
  - Pop = txfifo_upstream_vld & txfifo_upstream_rdy.
  - Word pushed at edge N is visible at the output after edge N+1 when the buffer was empty.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - count=2: ustrm_rdy=0; a pop that cycle raises ustrm_rdy the next cycle.
  - count=0: pop impossible (vld=0); txfifo_upstream_rdy ignored.
  - Head data is stable while vld=1 and rdy=0.
- Reset mid-operation: buffered TX words are discarded; RX held fields return to reset values immediately.

Test Plan:
- Reset, then RX word with state=4'h3, protid=2'b01, data=128'hA5..A5, dvalid=1, crc=8'h5C, crc_valid=1, valid=1, vld=1 -> next cycle all fields equal; dstrm_state_chg=1; err_cnt=0. Following idle cycle -> pulses 0, state/data held.
- RX words with {dvalid=1, valid=0}, then {dvalid=1, crc_valid=1, valid=0}, then a clean word -> err_cnt=2. err_clr and an error word in the same cycle -> err_cnt=0.
- ERR_CNT_W=2 with 5 consecutive error words -> err_cnt=3, stays 3.
- TX push words W0,W1 with txfifo_upstream_rdy=0 -> ustrm_rdy=0 after the 2nd push; txfifo_upstream_data=W0 stable. Push W2 while full -> dropped. Raise rdy -> W0 then W1 out; ustrm_rdy=1 again.
- TX continuous push with rdy=1 and packing check: push ustrm_state=4'hF, valid=1, crc=8'h81 -> txfifo_upstream_data[3:0]=4'hF, [142:135]=8'h81, [144]=1 after 1 cycle. Streaming throughput 1 word/cycle with no gaps.
- Assert rst_wr_n low with 2 TX words buffered and a held RX state -> txfifo_upstream_vld=0 and dstrm_state=STATE_RST without a clock edge. ustrm_rdy=1 the first clock after release.
